// File: rtl/sqrt_operand_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : sqrt_operand_conditioner
//  Description : Registered, handshaked front end for the square-root core.
//                Classifies one IEEE-754 operand, resolves NaN / negative /
//                inf / zero to a final result, and normalises subnormals one
//                bit per cycle so the root core always sees a hidden-1
//                mantissa, a signed biased exponent and an exponent parity.
//  Revision    : 1.0 - initial release
// ============================================================================
module sqrt_operand_conditioner #(
    parameter int EXP_W = 11,
    parameter int MAN_W = 52
) (
    input  logic                     clk,
    input  logic                     rstN,
    input  logic                     inValid,
    output logic                     inReady,
    input  logic [EXP_W+MAN_W:0]     inData,
    output logic                     outValid,
    input  logic                     outReady,
    output logic                     bypass,
    output logic [EXP_W+MAN_W:0]     result,
    output logic                     isNaN,
    output logic                     isInf,
    output logic                     isZero,
    output logic                     isSubnormal,
    output logic [MAN_W:0]           normMantissa,
    output logic [EXP_W:0]           normExp,
    output logic                     expOdd
);

    localparam int                 c_SIZE = 1 + EXP_W + MAN_W;
    localparam logic [EXP_W+1:0]   c_BIAS = (EXP_W+2)'((1 << (EXP_W-1)) - 1);
    localparam logic [c_SIZE-1:0]  c_QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [EXP_W:0]     c_ONE  = {{EXP_W{1'b0}}, 1'b1};

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_NORM = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;

    logic              r_bypass;
    logic [c_SIZE-1:0] r_result;
    logic              r_nan;
    logic              r_inf;
    logic              r_zero;
    logic              r_sub;
    logic [MAN_W:0]    r_man;
    logic [EXP_W:0]    r_exp;

    // Operand fields and classification of the incoming word
    logic              w_sign;
    logic [EXP_W-1:0]  w_exp;
    logic [MAN_W-1:0]  w_man;
    logic              w_exp_ones;
    logic              w_exp_zero;
    logic              w_man_zero;
    logic              w_cls_nan;
    logic              w_cls_inf;
    logic              w_cls_zero;
    logic              w_cls_sub;
    logic              w_cls_bypass;
    logic [MAN_W:0]    w_shifted;
    logic [EXP_W+1:0]  w_unbiased;

    assign w_sign     = inData[c_SIZE-1];
    assign w_exp      = inData[MAN_W +: EXP_W];
    assign w_man      = inData[MAN_W-1:0];
    assign w_exp_ones = &w_exp;
    assign w_exp_zero = ~|w_exp;
    assign w_man_zero = ~|w_man;

    // Priority is folded in: a negative nonzero value (incl. -inf) is a NaN,
    // so inf and subnormal only survive for the remaining encodings.
    assign w_cls_nan    = (w_exp_ones & ~w_man_zero) | (w_sign & ~(w_exp_zero & w_man_zero));
    assign w_cls_inf    = w_exp_ones & ~w_cls_nan;
    assign w_cls_zero   = w_exp_zero & w_man_zero;
    assign w_cls_sub    = w_exp_zero & ~w_man_zero & ~w_cls_nan;
    assign w_cls_bypass = w_cls_nan | w_cls_inf | w_cls_zero;

    // One normalisation step: the shifter always starts with a zero MSB
    assign w_shifted = {r_man[MAN_W-1:0], 1'b0};

    // State register; reset drops any operand in flight
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (inValid) begin
                    w_next_state = w_cls_sub ? c_S_NORM : c_S_DONE;
                end
            end
            c_S_NORM: begin
                if (w_shifted[MAN_W]) begin
                    w_next_state = c_S_DONE;
                end
            end
            c_S_DONE: begin
                if (outReady) begin
                    w_next_state = c_S_IDLE;
                end
            end
            default: w_next_state = c_S_IDLE;
        endcase
    end

    // Operand capture, subnormal shift/decrement loop and clear on handoff
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_bypass <= 1'b0;
            r_result <= '0;
            r_nan    <= 1'b0;
            r_inf    <= 1'b0;
            r_zero   <= 1'b0;
            r_sub    <= 1'b0;
            r_man    <= '0;
            r_exp    <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (inValid) begin
                        r_nan    <= w_cls_nan;
                        r_inf    <= w_cls_inf;
                        r_zero   <= w_cls_zero;
                        r_sub    <= w_cls_sub;
                        r_bypass <= w_cls_bypass;
                        if (w_cls_nan) begin
                            r_result <= c_QNAN;
                        end else if (w_cls_bypass) begin
                            r_result <= inData;
                        end else begin
                            r_result <= '0;
                        end
                        if (w_cls_bypass) begin
                            r_man <= '0;
                            r_exp <= '0;
                        end else if (w_cls_sub) begin
                            // Subnormals carry an effective exponent of 1
                            r_man <= {1'b0, w_man};
                            r_exp <= c_ONE;
                        end else begin
                            r_man <= {1'b1, w_man};
                            r_exp <= {1'b0, w_exp};
                        end
                    end
                end
                c_S_NORM: begin
                    r_man <= w_shifted;
                    r_exp <= r_exp - c_ONE;
                end
                c_S_DONE: begin
                    if (outReady) begin
                        r_bypass <= 1'b0;
                        r_result <= '0;
                        r_nan    <= 1'b0;
                        r_inf    <= 1'b0;
                        r_zero   <= 1'b0;
                        r_sub    <= 1'b0;
                        r_man    <= '0;
                        r_exp    <= '0;
                    end
                end
                default: begin
                    r_man <= '0;
                    r_exp <= '0;
                end
            endcase
        end
    end

    // Parity of the unbiased exponent, in sign-extended arithmetic
    assign w_unbiased = {r_exp[EXP_W], r_exp} - c_BIAS;

    assign inReady  = (r_state == c_S_IDLE);
    assign outValid = (r_state == c_S_DONE);

    // Fields are only visible while the result is presented; the shifter
    // contents during normalisation stay internal.
    assign bypass       = outValid & r_bypass;
    assign result       = outValid ? r_result : '0;
    assign isNaN        = outValid & r_nan;
    assign isInf        = outValid & r_inf;
    assign isZero       = outValid & r_zero;
    assign isSubnormal  = outValid & r_sub;
    assign normMantissa = outValid ? r_man : '0;
    assign normExp      = outValid ? r_exp : '0;
    assign expOdd       = outValid & ~r_bypass & w_unbiased[0];

endmodule
`default_nettype wire
